seg7_message_player: RTL and testbench
======================================

# seg7_message_player

Parametrised seven-segment message player: steps through a compile-time message of 5-bit glyph codes and drives one digit at a programmable rate. It is the successor to the fixed "HELLO ASIC" flasher and sits directly behind the TinyTapeout `io_out` pins. It adds configurable message length, segment polarity and tick rate. It also adds start, pause and one-shot control, plus status outputs.

## Interface
- `PRESCALE_W`, 22: prescaler width; at speed 0 the tick period is 2^PRESCALE_W cycles; minimum 4.
- `MSG_LEN`, 16: number of message slots, 1..32.
- `MSG`, all 0x1F: packed message, MSG_LEN*5 bits; slot i is `MSG[5*i+4:5*i]`.
- `ACTIVE_LOW`, 1: 1 selects common anode (all outputs inverted); 0 selects common cathode.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: single-cycle pulse; (re)starts playback at slot 0.
- `pause` in 1: level; freezes the prescaler and state while high.
- `oneshot` in 1: level; 1 stops at end of message, 0 loops.
- `speed` in 2: tick period is 2^(PRESCALE_W−speed) cycles.
- `seg_out` out 8: {dp,g,f,e,d,c,b,a}, polarity per ACTIVE_LOW, registered.
- `char_idx` out 5: current slot index.
- `busy` out 1: high in SHOW or GAP.
- `done` out 1: one-cycle pulse at one-shot completion.

## Operation
- Glyph codes, active-high values shown:
  - 0x00–0x0F: hex glyphs 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
  - 0x10 H=76, 0x11 L=38, 0x12 P=73, 0x13 U=3E, 0x14 r=50, 0x15 n=54, 0x16 dash=40.
  - 0x1E: END marker, never displayed.
  - 0x1F and all other codes: blank (00).
  - dp is always 0 (active-high).
  - With ACTIVE_LOW=1, every bit is inverted, so H=89 and blank=FF.
- States:
  - IDLE: `seg_out` blank.
  - SHOW: displays `MSG[char_idx]`.
  - GAP: displays blank.
  - DONE: lasts one cycle, `done`=1, then IDLE.
- Prescaler: free-running counter cleared on `start`. A tick fires when the low PRESCALE_W−speed bits are all ones.
- Transitions:
  - IDLE + `start` → SHOW, `char_idx`=0. If slot 0 is END, go to DONE instead.
  - SHOW + tick → GAP if the gap feature is compiled in; otherwise advance.
  - GAP + tick → advance.
- Advance: n = `char_idx`+1.
  - If n == MSG_LEN or slot n is END: go to DONE if `oneshot`=1, else SHOW with `char_idx`=0.
  - Otherwise: SHOW with `char_idx`=n.
- `start` in any state restarts at slot 0 with the prescaler cleared. `start` has priority over a tick in the same cycle.
- `pause`=1: prescaler, state and `char_idx` hold. `start` still acts during pause.
- `oneshot` is sampled only at advance.
- `speed` may change at any time; the new tick period takes effect on the next prescaler wrap of the new width.

## Timing
- Reset values: state IDLE, `seg_out` blank (FF or 00), `char_idx`=0, `busy`=0, `done`=0, prescaler 0.
- Reset mid-playback returns to these values on the next edge.
- `start` at edge k: `seg_out` shows the slot-0 glyph and `busy`=1 after edge k+1 (1-cycle latency).
- A tick at edge k is reflected on `seg_out` and `char_idx` after edge k+1.
- `done` is high for exactly one cycle. `busy` drops in that same cycle.
- A wrap in loop mode has no DONE cycle.
- MSG_LEN=1 in loop mode redisplays slot 0 on every advance.

## Configuration
- `SEG7_MSG_GAP_EN` defined: a blank GAP phase of one tick period is inserted after every character. This keeps repeated letters distinct; each character costs 2 ticks.
- Not defined: GAP state is absent; characters show back-to-back at 1 tick each.

## Test plan
Bench parameters: PRESCALE_W=4, MSG_LEN=8, ACTIVE_LOW=1, MSG = H,E,L,L,0,END,…; speed 0 (tick every 16 cycles).

1. Reset held 3 cycles → `seg_out`=FF, `char_idx`=0, `busy`=0, `done`=0.
2. Gap on, oneshot=1, `start` pulse → `seg_out` sequence 89,FF,86,FF,C7,FF,C7,FF,C0,FF, each held 16 cycles. Then `done` pulses once, `busy`=0, `seg_out`=FF.
3. Gap off, oneshot=0 → 89,86,C7,C7,C0, then wraps to 89 with no `done` pulse.
4. `pause` high for 40 cycles while showing E → `seg_out` stays 86 and `char_idx` stays 1. Playback resumes with the remaining tick count intact.
5. `start` pulse while showing slot 3 → next cycle `seg_out`=89, `char_idx`=0. Reset asserted mid-GAP → all reset values.
6. speed=2 → each glyph held 4 cycles. MSG slot 0 = END with `start` → `done` pulse after 1 cycle, `busy` never high.

Source files
------------

// File: rtl/seg7_message_player.sv
// -----------------------------------------------------------------------------
// seg7_message_player
//
// Steps through a compile-time message of 5-bit glyph codes and drives one
// seven-segment digit. The tick rate, segment polarity and message length are
// configurable. Playback supports start, pause and one-shot control, and the
// block reports status.
//
// Optional feature macro: SEG7_MSG_GAP_EN
//   defined     : a blank GAP phase of one tick period follows every character,
//                 so each character costs two ticks.
//   not defined : characters are shown back-to-back, one tick each.
//
// Parameters
//   PRESCALE_W : prescaler width (>= 4); speed 0 ticks every 2^PRESCALE_W cycles
//   MSG_LEN    : number of message slots, 1..32
//   MSG        : packed message, slot i = MSG[5*i+4:5*i]
//   ACTIVE_LOW : 1 = common anode (all segment outputs inverted)
//
// Ports
//   clk      in  : clock
//   reset    in  : synchronous, active-high reset
//   start    in  : single-cycle pulse, (re)starts playback at slot 0
//   pause    in  : level, freezes prescaler, state and slot index
//   oneshot  in  : level, 1 = stop at end of message, 0 = loop
//   speed    in  : tick period is 2^(PRESCALE_W-speed) cycles
//   seg_out  out : {dp,g,f,e,d,c,b,a}, registered
//   char_idx out : current slot index, registered
//   busy     out : high while a character or gap is on display
//   done     out : one-cycle pulse at one-shot completion
// -----------------------------------------------------------------------------
module seg7_message_player #(
    parameter int                   PRESCALE_W = 22,
    parameter int                   MSG_LEN    = 16,
    parameter logic [MSG_LEN*5-1:0] MSG        = {MSG_LEN{5'h1F}},
    parameter bit                   ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       oneshot,
    input  logic [1:0] speed,
    output logic [7:0] seg_out,
    output logic [4:0] char_idx,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [4:0] CODE_END  = 5'h1E;
    localparam logic [7:0] SEG_BLANK = ACTIVE_LOW ? 8'hFF : 8'h00;

`ifdef SEG7_MSG_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    // Active-high glyph for a code; dp is always off.
    function automatic logic [7:0] glyph(input logic [4:0] code);
        logic [6:0] g;
        case (code)
            5'h00:   g = 7'h3F;
            5'h01:   g = 7'h06;
            5'h02:   g = 7'h5B;
            5'h03:   g = 7'h4F;
            5'h04:   g = 7'h66;
            5'h05:   g = 7'h6D;
            5'h06:   g = 7'h7D;
            5'h07:   g = 7'h07;
            5'h08:   g = 7'h7F;
            5'h09:   g = 7'h6F;
            5'h0A:   g = 7'h77;
            5'h0B:   g = 7'h7C;
            5'h0C:   g = 7'h39;
            5'h0D:   g = 7'h5E;
            5'h0E:   g = 7'h79;
            5'h0F:   g = 7'h71;
            5'h10:   g = 7'h76;   // H
            5'h11:   g = 7'h38;   // L
            5'h12:   g = 7'h73;   // P
            5'h13:   g = 7'h3E;   // U
            5'h14:   g = 7'h50;   // r
            5'h15:   g = 7'h54;   // n
            5'h16:   g = 7'h40;   // dash
            default: g = 7'h00;   // blank, including END
        endcase
        return {1'b0, g};
    endfunction

    // Message unpacked into a full 32-entry table. Slots beyond MSG_LEN read
    // as END so a 5-bit index never leaves the table and the "next slot is
    // END" test covers the end-of-message case for MSG_LEN < 32.
    logic [4:0] slot_code [32];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_slot
            if (gi < MSG_LEN) begin : g_used
                assign slot_code[gi] = MSG[5*gi +: 5];
            end else begin : g_pad
                assign slot_code[gi] = CODE_END;
            end
        end
    endgenerate

    logic [1:0]            state_q,    state_d;
    logic [4:0]            idx_q,      idx_d;
    logic [PRESCALE_W-1:0] presc_q,    presc_d;
    logic [7:0]            seg_q,      seg_d;
    logic [4:0]            char_idx_q, char_idx_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;

    logic [PRESCALE_W-1:0] tick_mask;
    logic                  tick;
    logic [5:0]            next_n;
    logic                  next_wraps;

    // Tick when the low PRESCALE_W-speed bits of the prescaler are all ones.
    // The mask is recomputed every cycle, so a speed change applies from the
    // next wrap of the new width.
    always_comb begin
        tick_mask = {PRESCALE_W{1'b1}} >> speed;
        tick      = (presc_q & tick_mask) == tick_mask;
    end

    // Next slot is 6 bits wide so that n == 32 is representable.
    always_comb begin
        next_n     = {1'b0, idx_q} + 6'd1;
        next_wraps = (next_n == 6'(MSG_LEN)) || (slot_code[next_n[4:0]] == CODE_END);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        presc_d = presc_q;

        if (start) begin
            // Start wins over any tick in the same cycle.
            presc_d = '0;
            idx_d   = '0;
            state_d = (slot_code[0] == CODE_END) ? ST_DONE : ST_SHOW;
        end else begin
            if (!pause) begin
                presc_d = presc_q + PRESCALE_W'(1);
            end

            case (state_q)
                ST_SHOW, ST_GAP: begin
                    if (!pause && tick) begin
                        if (GAP_EN && state_q == ST_SHOW) begin
                            state_d = ST_GAP;
                        end else if (next_wraps) begin
                            // oneshot is only looked at here, at the advance.
                            if (oneshot) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_SHOW;
                                idx_d   = '0;
                            end
                        end else begin
                            state_d = ST_SHOW;
                            idx_d   = next_n[4:0];
                        end
                    end
                end
                // DONE is left unconditionally so the done pulse is always a
                // single cycle, even if pause is held. char_idx keeps the last
                // slot shown.
                ST_DONE: state_d = ST_IDLE;
                default: ;
            endcase
        end
    end

    // Outputs are registered from the current state, giving one cycle of
    // latency from a state change to the pins.
    always_comb begin
        seg_d      = SEG_BLANK;
        char_idx_d = idx_q;
        busy_d     = (state_q == ST_SHOW) || (state_q == ST_GAP);
        done_d     = (state_q == ST_DONE);
        if (state_q == ST_SHOW) begin
            seg_d = ACTIVE_LOW ? ~glyph(slot_code[idx_q]) : glyph(slot_code[idx_q]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            presc_q    <= '0;
            seg_q      <= SEG_BLANK;
            char_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            presc_q    <= presc_d;
            seg_q      <= seg_d;
            char_idx_q <= char_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign seg_out  = seg_q;
    assign char_idx = char_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_seg7_message_player.sv
// -----------------------------------------------------------------------------
// tb_seg7_message_player
//
// Two instances share all inputs: dut0 plays H,E,L,L,0,END and dut1 has END in
// slot 0. A behavioural model derives the expected outputs from elapsed
// playback time (ticks so far -> character step -> slot / gap), pushes one
// expected output tuple per DUT per clock into a queue, and a monitor on the
// falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_seg7_message_player;

    localparam int PW  = 4;
    localparam int LEN = 8;
    localparam logic [LEN*5-1:0] MSG0 =
        {5'h1F, 5'h1F, 5'h1E, 5'h00, 5'h11, 5'h11, 5'h0E, 5'h10};
    localparam logic [LEN*5-1:0] MSG1 =
        {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h10, 5'h1E};

`ifdef SEG7_MSG_GAP_EN
    localparam int TPC = 2;   // ticks per character
`else
    localparam int TPC = 1;
`endif

    localparam logic [7:0] HEX_TAB [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    localparam logic [7:0] LET_TAB [7]  = '{8'h76, 8'h38, 8'h73, 8'h3E, 8'h50, 8'h54, 8'h40};

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_DONE = 2;

    typedef struct packed {
        logic [7:0] seg;
        logic [4:0] idx;
        logic       busy;
        logic       done;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset, start, pause, oneshot;
    logic [1:0] speed;
    logic [7:0] seg_w  [2];
    logic [4:0] idx_w  [2];
    logic       busy_w [2];
    logic       done_w [2];

    always #5 clk = ~clk;

    seg7_message_player #(.PRESCALE_W(PW), .MSG_LEN(LEN), .MSG(MSG0), .ACTIVE_LOW(1'b1)) dut0 (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .oneshot(oneshot), .speed(speed),
        .seg_out(seg_w[0]), .char_idx(idx_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    seg7_message_player #(.PRESCALE_W(PW), .MSG_LEN(LEN), .MSG(MSG1), .ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .oneshot(oneshot), .speed(speed),
        .seg_out(seg_w[1]), .char_idx(idx_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    // ---------------- reference model ----------------
    logic [4:0] m_msg  [2][LEN];
    int         m_len  [2];
    int         m_mode [2];
    int         m_t    [2];   // un-paused cycles since start
    int         m_idx  [2];

    obs_t exp_q0 [$];
    obs_t exp_q1 [$];
    int   n_pushed = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   end_req  = 1'b0;
    bit   end_done = 1'b0;

    function automatic logic [7:0] glyph_ref(input logic [4:0] code);
        if (code < 5'h10)       return HEX_TAB[code[3:0]];
        else if (code <= 5'h16) return LET_TAB[int'(code) - 16];
        else                    return 8'h00;
    endfunction

    function automatic obs_t model_out(input int d, input int per);
        obs_t o;
        o.seg  = 8'h00;
        o.idx  = 5'(m_idx[d]);
        o.busy = (m_mode[d] == M_PLAY);
        o.done = (m_mode[d] == M_DONE);
        if (m_mode[d] == M_PLAY && ((m_t[d] / per) % TPC) == 0)
            o.seg = glyph_ref(m_msg[d][m_idx[d]]);
        o.seg = ~o.seg;   // common anode
        return o;
    endfunction

    task automatic model_step(input int d);
        obs_t o;
        int   per, p, s;
        per = 1 << (PW - int'(speed));
        if (reset) o = '{seg: 8'hFF, idx: 5'd0, busy: 1'b0, done: 1'b0};
        else       o = model_out(d, per);
        if (d == 0) exp_q0.push_back(o);
        else        exp_q1.push_back(o);
        n_pushed++;

        if (reset) begin
            m_mode[d] = M_IDLE; m_idx[d] = 0; m_t[d] = 0;
        end else if (start) begin
            m_t[d]    = 0;
            m_idx[d]  = 0;
            m_mode[d] = (m_len[d] == 0) ? M_DONE : M_PLAY;
        end else if (m_mode[d] == M_DONE) begin
            m_mode[d] = M_IDLE;
        end else if (m_mode[d] == M_PLAY && !pause) begin
            m_t[d]++;
            if (m_t[d] % per == 0) begin
                p = m_t[d] / per;
                if (p % TPC == 0) begin
                    s = p / TPC;
                    if (s % m_len[d] == 0) begin
                        if (oneshot) m_mode[d] = M_DONE;
                        else         m_idx[d]  = 0;
                    end else begin
                        m_idx[d] = s % m_len[d];
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) model_step(d);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    // ---------------- monitor ----------------
    obs_t prev_obs [2];

    always @(negedge clk) begin
        obs_t e, a;
        bit   have;
        for (int d = 0; d < 2; d++) begin
            have = 1'b0;
            if (d == 0 && exp_q0.size() != 0) begin e = exp_q0.pop_front(); have = 1'b1; end
            if (d == 1 && exp_q1.size() != 0) begin e = exp_q1.pop_front(); have = 1'b1; end
            if (have) begin
                a.seg  = seg_w[d];
                a.idx  = idx_w[d];
                a.busy = busy_w[d];
                a.done = done_w[d];
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL out%0d cyc %0d: got seg=%02h idx=%0d busy=%0b done=%0b, expected seg=%02h idx=%0d busy=%0b done=%0b",
                             d, cyc, a.seg, a.idx, a.busy, a.done, e.seg, e.idx, e.busy, e.done);
                end
                if (a !== prev_obs[d])
                    $display("dut%0d cyc %0d: seg=%02h idx=%0d busy=%0b done=%0b",
                             d, cyc, a.seg, a.idx, a.busy, a.done);
                prev_obs[d] = a;
            end
        end
        if (end_req && !end_done) begin
            n_checks++;
            if (n_checks - 1 != n_pushed || exp_q0.size() != 0 || exp_q1.size() != 0) begin
                n_fail++;
                $display("FAIL completeness: checked %0d, pushed %0d", n_checks - 1, n_pushed);
            end
            end_done = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [LEN*5-1:0] pk [2];
        pk[0] = MSG0;
        pk[1] = MSG1;
        for (int d = 0; d < 2; d++) begin
            m_len[d] = LEN;
            for (int i = LEN - 1; i >= 0; i--) begin
                m_msg[d][i] = pk[d][5*i +: 5];
                if (m_msg[d][i] == 5'h1E) m_len[d] = i;
            end
            m_mode[d] = M_IDLE; m_t[d] = 0; m_idx[d] = 0;
        end

        reset = 1'b1; start = 1'b0; pause = 1'b0; oneshot = 1'b1; speed = 2'd0;

        // Reset held three cycles, then idle.
        run(3);
        reset = 1'b0;
        run(4);

        // One-shot playback to completion.
        oneshot = 1'b1;
        pulse_start();
        run(200);

        // Loop mode with wrap.
        oneshot = 1'b0;
        pulse_start();
        run(220);

        // Pause while E is on display.
        pulse_start();
        run(20);
        pause = 1'b1;
        run(40);
        pause = 1'b0;
        run(60);

        // Restart mid-message, then reset mid-playback.
        pulse_start();
        run(3 * 16 * TPC + 5);
        pulse_start();
        run(24);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(6);

        // Fast speed, one-shot; dut1 hits END at slot 0.
        speed   = 2'd2;
        oneshot = 1'b1;
        pulse_start();
        run(60);

        // Randomised phase.
        for (int r = 0; r < 40; r++) begin
            int len;
            speed   = 2'($urandom_range(0, 3));
            oneshot = 1'($urandom_range(0, 1));
            pulse_start();
            len = $urandom_range(20, 150);
            for (int c = 0; c < len; c++) begin
                pause = ($urandom_range(0, 7) == 0);
                start = ($urandom_range(0, 99) == 0);
                reset = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 49) == 0) oneshot = ~oneshot;
                cycle();
            end
            pause = 1'b0; start = 1'b0; reset = 1'b0;
        end
        run(2);

        end_req = 1'b1;
        for (int w = 0; w < 4 && !end_done; w++) @(negedge clk);
        #1;
        if (!end_done) begin
            n_fail++;
            $display("FAIL end_sync: monitor did not finish, got 0 required 1");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
